// File: rtl/regfile_wr_decode_64x32.sv
// 32 x 64-bit ARM register file: one-hot write decode, two combinational read ports
// built from 4:1 mux trees, write-through bypass, and X31 (XZR) hardwired to zero.
module regfile_wr_decode_64x32 #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    logic [NUM_REGS-1:0]   wr_en;
    logic [DATA_WIDTH-1:0] rd_vec [NUM_REGS];
    logic                  byp1;
    logic                  byp2;
    logic [DATA_WIDTH-1:0] sel1;
    logic [DATA_WIDTH-1:0] sel2;

    // NOTE: every variable driven in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_en[i] = RegWrite && (WriteRegister == 5'(i)) && (i != ZERO_REG);
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign rd_vec[i] = '0;
        end else begin : g_store
            logic [DATA_WIDTH-1:0] reg_q;
            logic [DATA_WIDTH-1:0] reg_d;

            always_comb reg_d = wr_en[i] ? WriteData : reg_q;

            // NOTE: the register file is architectural state, so every entry is reset;
            // non-blocking assignment keeps all flops updating from pre-edge values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) reg_q <= '0;
                else        reg_q <= reg_d;
            end

            assign rd_vec[i] = reg_q;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] mux4(
        input logic [DATA_WIDTH-1:0] d0,
        input logic [DATA_WIDTH-1:0] d1,
        input logic [DATA_WIDTH-1:0] d2,
        input logic [DATA_WIDTH-1:0] d3,
        input logic [1:0]            s
    );
        case (s)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return d3;
        endcase
    endfunction

    // 32:1 select: eight 4:1 muxes on addr[1:0], two 4:1 on addr[3:2], then 2:1 on addr[4].
    function automatic logic [DATA_WIDTH-1:0] read_tree(
        input logic [4:0]            addr,
        input logic [DATA_WIDTH-1:0] r [NUM_REGS]
    );
        logic [DATA_WIDTH-1:0] l1 [8];
        logic [DATA_WIDTH-1:0] l2 [2];
        for (int g = 0; g < 8; g++) begin
            l1[g] = mux4(r[4*g], r[4*g+1], r[4*g+2], r[4*g+3], addr[1:0]);
        end
        for (int h = 0; h < 2; h++) begin
            l2[h] = mux4(l1[4*h], l1[4*h+1], l1[4*h+2], l1[4*h+3], addr[3:2]);
        end
        return addr[4] ? l2[1] : l2[0];
    endfunction

    always_comb begin
        sel1 = read_tree(ReadRegister1, rd_vec);
        sel2 = read_tree(ReadRegister2, rd_vec);
        byp1 = RegWrite && (WriteRegister == ReadRegister1) && (WriteRegister != 5'(ZERO_REG));
        byp2 = RegWrite && (WriteRegister == ReadRegister2) && (WriteRegister != 5'(ZERO_REG));
    end

    // Reset forces both ports to zero, which also suppresses bypass while rst_n is low.
    assign ReadData1 = !rst_n ? '0 : (byp1 ? WriteData : sel1);
    assign ReadData2 = !rst_n ? '0 : (byp2 ? WriteData : sel2);

endmodule

// File: tb/tb_regfile_wr_decode_64x32.sv
// Self-checking bench for regfile_wr_decode_64x32: vector table, directed corner
// sequences and randomized traffic against an array-based reference model.
module tb_regfile_wr_decode_64x32;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int n_total = 0;
    int n_pass  = 0;

    logic [63:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } vec_t;

    vec_t vecs [$];

    regfile_wr_decode_64x32 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Inputs change just after the falling edge, away from the active edge.
    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        #1;
    endtask

    // Advance past the rising edge and apply the architectural write rule to the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n && RegWrite && WriteRegister != 5'd31) model[WriteRegister] = WriteData;
    endtask

    function automatic logic [63:0] exp_read(input logic [4:0] ra);
        if (!rst_n || ra == 5'd31) return 64'h0;
        if (RegWrite && WriteRegister == ra) return WriteData;
        return model[ra];
    endfunction

    function automatic logic [63:0] pat(input int i);
        return 64'(32'hA5A5_0000 | 32'(i));
    endfunction

    initial begin
        vec_t v;
        rst_n = 1'b0;
        RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        foreach (model[i]) model[i] = 64'h0;

        // Reset state
        #12;
        check("reset_rd1", ReadData1, 64'h0);
        check("reset_rd2", ReadData2, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle after writing X5
        drive(1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd5);
        check("x5_bypass", ReadData1, 64'hDEAD_BEEF);
        tick();
        drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
        check("x5_stored", ReadData1, 64'hDEAD_BEEF);
        #1;
        rst_n = 1'b0;
        foreach (model[i]) model[i] = 64'h0;
        #0.1;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #0.1;
            check($sformatf("async_rst_rd1_%0d", i), ReadData1, 64'h0);
            check($sformatf("async_rst_rd2_%0d", i), ReadData2, 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
        check("x5_cleared", ReadData1, 64'h0);

        // Vector table: write X0..X30 with bypass visible, then cross-read pairs
        for (int i = 0; i < 31; i++) begin
            v = '{1'b1, 5'(i), pat(i), 5'(i), 5'(i), pat(i), pat(i)};
            vecs.push_back(v);
        end
        for (int i = 0; i < 31; i++) begin
            v = '{1'b0, 5'd0, 64'h0, 5'(i), 5'(30 - i), pat(i), pat(30 - i)};
            vecs.push_back(v);
        end
        foreach (vecs[k]) begin
            drive(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].r1, vecs[k].r2);
            check($sformatf("vec%0d_rd1", k), ReadData1, vecs[k].exp1);
            check($sformatf("vec%0d_rd2", k), ReadData2, vecs[k].exp2);
            tick();
        end

        // XZR ignores writes and always reads zero
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
        check("xzr_same_rd1", ReadData1, 64'h0);
        check("xzr_same_rd2", ReadData2, 64'h0);
        tick();
        drive(1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
        check("xzr_next_rd1", ReadData1, 64'h0);
        check("xzr_next_rd2", ReadData2, 64'h0);
        tick();

        // Bypass on both ports, then stored value matches
        drive(1'b1, 5'd7, 64'h1111, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 64'h2222, 5'd7, 5'd7);
        check("byp_rd1", ReadData1, 64'h2222);
        check("byp_rd2", ReadData2, 64'h2222);
        tick();
        drive(1'b0, 5'd7, 64'h0, 5'd7, 5'd7);
        check("byp_after_rd1", ReadData1, 64'h2222);
        check("byp_after_rd2", ReadData2, 64'h2222);
        tick();

        // RegWrite low: hold, and no bypass despite index match
        drive(1'b1, 5'd3, 64'h33, 5'd0, 5'd0);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 5'd3, 64'h99, 5'd3, 5'd3);
            check($sformatf("hold_c%0d", c), ReadData1, 64'h33);
            tick();
        end

        // Reset asserted across an edge carrying a write: reset wins
        @(negedge clk);
        RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 64'h77;
        ReadRegister1 = 5'd2; ReadRegister2 = 5'd2;
        rst_n = 1'b0;
        foreach (model[i]) model[i] = 64'h0;
        #1;
        check("coll_rst_rd1", ReadData1, 64'h0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        RegWrite = 1'b0;
        #1;
        check("coll_x2_rd1", ReadData1, 64'h0);
        check("coll_x2_rd2", ReadData2, 64'h0);
        tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            logic [4:0] r1;
            logic [4:0] r2;
            wa = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(1'($urandom), wa, {$urandom, $urandom}, r1, r2);
            check($sformatf("rand%0d_rd1", n), ReadData1, exp_read(ReadRegister1));
            check($sformatf("rand%0d_rd2", n), ReadData2, exp_read(ReadRegister2));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
